fifo_flow_ctrl: RTL

Valid/ready flow controller that sits directly in front of the strobe-driven FIFO memory stage (`mem_test`-style: `CLK`/`RST`/`READ`/`WRITE`/`D`/`Q`, registered `Q`, no flags). Converts an upstream valid/ready stream into guarded `WRITE` strobes and issues `READ` strobes to deliver words to a downstream valid/ready stream. Tracks memory occupancy, so the memory never overflows or underflows. Absorbs the memory's one-cycle read latency in a 2-entry output buffer, sustaining 1 word/cycle under backpressure.

---
 rtl/fifo_flow_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_flow_ctrl.sv
`timescale 1ns/1ps
// fifo_flow_ctrl: valid/ready front end for a strobe-driven FIFO memory stage.
// Guards WRITE/READ with an occupancy count and hides the memory's read latency in a 2-deep output buffer.
module fifo_flow_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIZE_E = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [WIDTH-1:0]  S_DATA,
  output logic              MEM_RST,
  output logic              WRITE,
  output logic [WIDTH-1:0]  D,
  output logic              READ,
  input  logic [WIDTH-1:0]  Q,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [WIDTH-1:0]  M_DATA,
  output logic [SIZE_E+1:0] COUNT,
  output logic              EMPTY
);

  localparam int unsigned CW    = SIZE_E + 1;
  localparam int unsigned NW    = SIZE_E + 2;
  localparam int unsigned DEPTH = 1 << SIZE_E;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             rip_q, rip_d;
  logic [1:0]       o_cnt_q, o_cnt_d;
  logic [WIDTH-1:0] ob0_q, ob0_d;
  logic [WIDTH-1:0] ob1_q, ob1_d;

  logic             write_c;
  logic             read_c;
  logic             pop_c;
  logic [2:0]       o_proj_c;
  logic [1:0]       o_after_pop_c;

  // Handshake decode; S_READY depends on registered state only.
  always_comb begin
    S_READY  = (mem_cnt_q != DEPTH_C);
    M_VALID  = (o_cnt_q != 2'd0);
    M_DATA   = ob0_q;
    pop_c    = M_VALID & M_READY;
    write_c  = S_VALID & S_READY & RST_N;
    o_proj_c = 3'(o_cnt_q) + 3'(rip_q) - 3'(pop_c);
    // A read is issued only if its word is guaranteed a free buffer slot.
    read_c   = (mem_cnt_q != '0) && (o_proj_c < 3'd2);
  end

  assign WRITE   = write_c;
  assign READ    = read_c;
  assign D       = S_DATA;
  assign MEM_RST = ~RST_N;
  assign COUNT   = NW'(mem_cnt_q) + NW'(rip_q) + NW'(o_cnt_q);
  assign EMPTY   = (COUNT == '0);

  // Next-state: memory occupancy, read-in-flight flag, output buffer.
  always_comb begin
    mem_cnt_d     = mem_cnt_q + CW'(write_c) - CW'(read_c);
    rip_d         = read_c;
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;
    o_after_pop_c = o_cnt_q;
    if (pop_c) begin
      ob0_d         = ob1_q;
      o_after_pop_c = o_cnt_q - 2'd1;
    end
    if (rip_q) begin
      if (o_after_pop_c == 2'd0) begin
        ob0_d = Q;
      end else begin
        ob1_d = Q;
      end
    end
    o_cnt_d = o_after_pop_c + 2'(rip_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_cnt_q <= '0;
      rip_q     <= 1'b0;
      o_cnt_q   <= 2'd0;
      ob0_q     <= '0;
      ob1_q     <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      rip_q     <= rip_d;
      o_cnt_q   <= o_cnt_d;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
    end
  end

endmodule
